multi_channel_mixer: RTL and testbench

//  N-channel weighted audio mixer; parametrised successor to the two-input mixer in the labkit audio path.

---
 rtl/multi_channel_mixer_pkg.sv | 16 +
 rtl/multi_channel_mixer_weight_ctrl.sv | 57 +++++
 rtl/multi_channel_mixer.sv | 149 ++++++++++++++
 tb/tb_multi_channel_mixer.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/multi_channel_mixer_pkg.sv
// Shared types and width helpers for the multi-channel weighted mixer.
// The FSM state encoding and the accumulator width rule live here so the top level and the bench agree.
package multi_channel_mixer_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    SCALE = 2'd2
  } mixState_t;

  // Wide enough for NUM_CH full-scale products, so the running sum can never wrap.
  function automatic int accWidth(input int sampleW, input int weightW, input int numCh);
    return sampleW + weightW + $clog2(numCh);
  endfunction

endpackage

// File: rtl/multi_channel_mixer_weight_ctrl.sv
// Per-channel weight registers, adjusted by edge-detected fup/fdown on the channel chosen by sel.
// Runs independently of the mixer FSM; the top level takes a shadow copy when a sample is accepted.
module mixer_weight_ctrl
  import multi_channel_mixer_pkg::*;
#(
  parameter int NUM_CH   = 4,
  parameter int WEIGHT_W = 5,
  parameter int SEL_W    = $clog2(NUM_CH)
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         fup,
  input  logic                         fdown,
  input  logic [SEL_W-1:0]             sel,
  output logic [NUM_CH*WEIGHT_W-1:0]   weights
);

  localparam logic [WEIGHT_W-1:0] W_INIT = WEIGHT_W'(1) << (WEIGHT_W - 1);
  localparam logic [WEIGHT_W-1:0] W_MAX  = '1;

  logic                r_fupPrev;
  logic                r_fdownPrev;
  logic [WEIGHT_W-1:0] r_weight [NUM_CH];
  logic                w_up;
  logic                w_down;

  assign w_up   = fup & ~r_fupPrev;
  assign w_down = fdown & ~r_fdownPrev;

  // Simultaneous up and down edges cancel; a sel beyond NUM_CH-1 matches no channel.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_fupPrev   <= 1'b0;
      r_fdownPrev <= 1'b0;
      for (int i = 0; i < NUM_CH; i++) begin
        r_weight[i] <= W_INIT;
      end
    end else begin
      r_fupPrev   <= fup;
      r_fdownPrev <= fdown;
      for (int i = 0; i < NUM_CH; i++) begin
        if (i == int'(sel)) begin
          if (w_up && !w_down && r_weight[i] != W_MAX) begin
            r_weight[i] <= r_weight[i] + 1'b1;
          end else if (w_down && !w_up && r_weight[i] != '0) begin
            r_weight[i] <= r_weight[i] - 1'b1;
          end
        end
      end
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : gPack
    assign weights[g*WEIGHT_W +: WEIGHT_W] = r_weight[g];
  end

endmodule

// File: rtl/multi_channel_mixer.sv
// N-channel weighted mixer: one sequential MAC sums weighted samples, then the sum is
// scaled down by 2^WEIGHT_W and saturated to the sample width.
module multi_channel_mixer
  import multi_channel_mixer_pkg::*;
#(
  parameter int NUM_CH   = 4,
  parameter int SAMPLE_W = 18,
  parameter int WEIGHT_W = 5
) (
  input  logic                                clock,
  input  logic                                reset,
  input  logic                                ready,
  input  logic [NUM_CH*SAMPLE_W-1:0]          audio_in,
  input  logic [NUM_CH-1:0]                   mute,
  input  logic [$clog2(NUM_CH)-1:0]           sel,
  input  logic                                fup,
  input  logic                                fdown,
  output logic signed [SAMPLE_W-1:0]          audio_out,
  output logic                                out_valid,
  output logic [NUM_CH*WEIGHT_W-1:0]          weights,
  output logic                                clip,
  output logic                                overrun
);

  localparam int SEL_W  = $clog2(NUM_CH);
  localparam int PROD_W = SAMPLE_W + WEIGHT_W;
  localparam int ACC_W  = accWidth(SAMPLE_W, WEIGHT_W, NUM_CH);
  localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-SAMPLE_W+1){1'b0}}, {(SAMPLE_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-SAMPLE_W+1){1'b1}}, {(SAMPLE_W-1){1'b0}}};

  mixState_t                      r_state;
  mixState_t                      w_nextState;
  logic [NUM_CH*SAMPLE_W-1:0]     r_samples;
  logic [NUM_CH-1:0]              r_mute;
  logic [NUM_CH*WEIGHT_W-1:0]     r_wShadow;
  logic signed [ACC_W-1:0]        r_acc;
  logic [SEL_W-1:0]               r_idx;
  logic signed [SAMPLE_W-1:0]     r_audioOut;
  logic                           r_outValid;
  logic                           r_clip;
  logic                           r_overrun;

  logic [NUM_CH*WEIGHT_W-1:0]     w_weights;
  logic signed [SAMPLE_W-1:0]     w_x;
  logic [WEIGHT_W-1:0]            w_w;
  logic signed [PROD_W-1:0]       w_xExt;
  logic signed [PROD_W-1:0]       w_wExt;
  logic signed [PROD_W-1:0]       w_prod;
  logic signed [ACC_W-1:0]        w_term;
  logic signed [ACC_W-1:0]        w_scaled;
  logic signed [SAMPLE_W-1:0]     w_sat;
  logic                           w_clipNow;

  mixer_weight_ctrl #(
    .NUM_CH   (NUM_CH),
    .WEIGHT_W (WEIGHT_W),
    .SEL_W    (SEL_W)
  ) uWeightCtrl (
    .clock   (clock),
    .reset   (reset),
    .fup     (fup),
    .fdown   (fdown),
    .sel     (sel),
    .weights (w_weights)
  );

  // Weight is zero-extended so the product is a plain signed multiply of exact width.
  assign w_x    = r_samples[r_idx*SAMPLE_W +: SAMPLE_W];
  assign w_w    = r_wShadow[r_idx*WEIGHT_W +: WEIGHT_W];
  assign w_xExt = {{WEIGHT_W{w_x[SAMPLE_W-1]}}, w_x};
  assign w_wExt = {{SAMPLE_W{1'b0}}, w_w};
  assign w_prod = w_xExt * w_wExt;
  assign w_term = r_mute[r_idx] ? '0 : {{(ACC_W-PROD_W){w_prod[PROD_W-1]}}, w_prod};

  assign w_scaled = r_acc >>> WEIGHT_W;

  always_comb begin
    w_clipNow = 1'b0;
    w_sat     = w_scaled[SAMPLE_W-1:0];
    if (w_scaled > SAT_MAX) begin
      w_sat     = SAT_MAX[SAMPLE_W-1:0];
      w_clipNow = 1'b1;
    end else if (w_scaled < SAT_MIN) begin
      w_sat     = SAT_MIN[SAMPLE_W-1:0];
      w_clipNow = 1'b1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_nextState;
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE:    if (ready) w_nextState = ACCUM;
      ACCUM:   if (r_idx == SEL_W'(NUM_CH - 1)) w_nextState = SCALE;
      SCALE:   w_nextState = IDLE;
      default: w_nextState = IDLE;
    endcase
  end

  // A ready outside IDLE is dropped and only flagged; the in-flight sum carries on untouched.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_samples  <= '0;
      r_mute     <= '0;
      r_wShadow  <= '0;
      r_acc      <= '0;
      r_idx      <= '0;
      r_audioOut <= '0;
      r_outValid <= 1'b0;
      r_clip     <= 1'b0;
      r_overrun  <= 1'b0;
    end else begin
      r_outValid <= 1'b0;
      if (ready && r_state != IDLE) r_overrun <= 1'b1;
      case (r_state)
        IDLE: begin
          if (ready) begin
            r_samples <= audio_in;
            r_mute    <= mute;
            r_wShadow <= w_weights;
            r_acc     <= '0;
            r_idx     <= '0;
          end
        end
        ACCUM: begin
          r_acc <= r_acc + w_term;
          r_idx <= r_idx + 1'b1;
        end
        SCALE: begin
          r_audioOut <= w_sat;
          r_outValid <= 1'b1;
          if (w_clipNow) r_clip <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign audio_out = r_audioOut;
  assign out_valid = r_outValid;
  assign weights   = w_weights;
  assign clip      = r_clip;
  assign overrun   = r_overrun;

endmodule

// File: tb/tb_multi_channel_mixer.sv
// Self-checking bench for multi_channel_mixer: directed cases plus randomized transactions
// compared against an arithmetic model of the weighted mix.
module tb_multi_channel_mixer;

  localparam int NUM_CH   = 4;
  localparam int SAMPLE_W = 18;
  localparam int WEIGHT_W = 5;
  localparam int SEL_W    = 2;
  localparam int W_MAX    = 31;
  localparam int W_INIT   = 16;
  localparam longint OUT_MAX = 131071;
  localparam longint OUT_MIN = -131072;

  logic                          clock = 1'b0;
  logic                          reset;
  logic                          ready;
  logic [NUM_CH*SAMPLE_W-1:0]    audioIn;
  logic [NUM_CH-1:0]             mute;
  logic [SEL_W-1:0]              sel;
  logic                          fup;
  logic                          fdown;
  logic signed [SAMPLE_W-1:0]    audioOut;
  logic                          outValid;
  logic [NUM_CH*WEIGHT_W-1:0]    weights;
  logic                          clip;
  logic                          overrun;

  int  compareCount  = 0;
  int  mismatchCount = 0;
  int  modelW [NUM_CH];
  bit  modelClip;
  bit  modelOverrun;

  always #5 clock = ~clock;

  multi_channel_mixer #(
    .NUM_CH   (NUM_CH),
    .SAMPLE_W (SAMPLE_W),
    .WEIGHT_W (WEIGHT_W)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .ready     (ready),
    .audio_in  (audioIn),
    .mute      (mute),
    .sel       (sel),
    .fup       (fup),
    .fdown     (fdown),
    .audio_out (audioOut),
    .out_valid (outValid),
    .weights   (weights),
    .clip      (clip),
    .overrun   (overrun)
  );

  task automatic checkOutput(input string tag, input longint got, input longint exp);
    compareCount++;
    if (got != exp) begin
      mismatchCount++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic [NUM_CH*WEIGHT_W-1:0] modelPacked();
    logic [NUM_CH*WEIGHT_W-1:0] p;
    p = '0;
    for (int c = 0; c < NUM_CH; c++) p[c*WEIGHT_W +: WEIGHT_W] = WEIGHT_W'(modelW[c]);
    return p;
  endfunction

  // Weighted sum, floor-divided by 2^WEIGHT_W, then clamped to the signed sample range.
  function automatic longint mixModel(input logic [NUM_CH*SAMPLE_W-1:0] s,
                                      input logic [NUM_CH-1:0] m, output bit sat);
    longint sum;
    longint q;
    longint div;
    sum = 0;
    div = longint'(1) << WEIGHT_W;
    for (int c = 0; c < NUM_CH; c++) begin
      if (!m[c]) sum += longint'($signed(s[c*SAMPLE_W +: SAMPLE_W])) * longint'(modelW[c]);
    end
    q = sum / div;
    if ((sum % div) != 0 && sum < 0) q = q - 1;
    sat = 1'b0;
    if (q > OUT_MAX) begin
      q = OUT_MAX;
      sat = 1'b1;
    end else if (q < OUT_MIN) begin
      q = OUT_MIN;
      sat = 1'b1;
    end
    return q;
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic doReset();
    ready = 1'b0;
    fup   = 1'b0;
    fdown = 1'b0;
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    for (int c = 0; c < NUM_CH; c++) modelW[c] = W_INIT;
    modelClip    = 1'b0;
    modelOverrun = 1'b0;
  endtask

  task automatic pulseWeight(input int ch, input bit up, input bit dn);
    sel   = SEL_W'(ch);
    fup   = up;
    fdown = dn;
    tick();
    if (up && !dn && modelW[ch] < W_MAX) modelW[ch]++;
    if (dn && !up && modelW[ch] > 0) modelW[ch]--;
    fup   = 1'b0;
    fdown = 1'b0;
    tick();
  endtask

  task automatic applyStimulus(input string tag, input logic [NUM_CH*SAMPLE_W-1:0] s,
                               input logic [NUM_CH-1:0] m, input bit adjustMidway);
    longint expOut;
    bit     sat;
    int     cycles;
    int     adjCh;
    expOut  = mixModel(s, m, sat);
    audioIn = s;
    mute    = m;
    ready   = 1'b1;
    tick();
    ready   = 1'b0;
    cycles  = 0;
    while (cycles < 20) begin
      if (adjustMidway && cycles == 1) begin
        adjCh = $urandom_range(0, NUM_CH - 1);
        sel   = SEL_W'(adjCh);
        fup   = 1'b1;
        if (modelW[adjCh] < W_MAX) modelW[adjCh]++;
      end
      if (cycles == 3) fup = 1'b0;
      tick();
      cycles++;
      if (outValid) break;
    end
    fup = 1'b0;
    modelClip = modelClip | sat;
    checkOutput({tag, "_latency"}, cycles, 5);
    checkOutput({tag, "_audio"}, $signed(audioOut), expOut);
    checkOutput({tag, "_clip"}, clip, modelClip);
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [NUM_CH*SAMPLE_W-1:0] s;
    int pulses;
    longint seenAudio;

    reset = 1'b0; ready = 1'b0; fup = 1'b0; fdown = 1'b0;
    audioIn = '0; mute = '0; sel = '0;

    // Reset and idle
    doReset();
    repeat (10) tick();
    checkOutput("rst_audio", $signed(audioOut), 0);
    checkOutput("rst_valid", outValid, 0);
    checkOutput("rst_clip", clip, 0);
    checkOutput("rst_overrun", overrun, 0);
    checkOutput("rst_weights", weights, modelPacked());

    // All channels 1000 at weight 16
    for (int c = 0; c < NUM_CH; c++) s[c*SAMPLE_W +: SAMPLE_W] = 18'd1000;
    applyStimulus("t2", s, 4'b0000, 1'b0);
    checkOutput("t2_const", $signed(audioOut), 2000);

    // Full weights, positive and negative full scale
    for (int c = 0; c < NUM_CH; c++) for (int k = 0; k < 15; k++) pulseWeight(c, 1'b1, 1'b0);
    checkOutput("t3_weights", weights, modelPacked());
    for (int c = 0; c < NUM_CH; c++) s[c*SAMPLE_W +: SAMPLE_W] = 18'h1FFFF;
    applyStimulus("t3_pos", s, 4'b0000, 1'b0);
    checkOutput("t3_pos_const", $signed(audioOut), OUT_MAX);
    checkOutput("t3_pos_clipset", clip, 1);
    for (int c = 0; c < NUM_CH; c++) s[c*SAMPLE_W +: SAMPLE_W] = 18'h20000;
    applyStimulus("t3_neg", s, 4'b0000, 1'b0);
    checkOutput("t3_neg_const", $signed(audioOut), OUT_MIN);

    // Weight saturation at max and zero, simultaneous edges cancel
    doReset();
    checkOutput("t4_clip_cleared", clip, 0);
    for (int k = 0; k < 20; k++) pulseWeight(2, 1'b1, 1'b0);
    checkOutput("t4_w2_max", weights[14:10], 31);
    checkOutput("t4_up_weights", weights, modelPacked());
    pulseWeight(2, 1'b1, 1'b1);
    checkOutput("t4_both", weights[14:10], 31);
    for (int k = 0; k < 40; k++) pulseWeight(2, 1'b0, 1'b1);
    checkOutput("t4_w2_zero", weights[14:10], 0);
    checkOutput("t4_down_weights", weights, modelPacked());

    // Mute and overrun
    doReset();
    audioIn = {18'd0, 18'd0, 18'd0, 18'd5000};
    mute    = 4'b0001;
    ready = 1'b1; tick();
    ready = 1'b0; tick();
    ready = 1'b1; tick();
    ready = 1'b0;
    pulses = 0;
    seenAudio = -1;
    for (int k = 0; k < 12; k++) begin
      tick();
      if (outValid) begin
        pulses++;
        seenAudio = $signed(audioOut);
      end
    end
    modelOverrun = 1'b1;
    checkOutput("t5_pulses", pulses, 1);
    checkOutput("t5_audio", seenAudio, 0);
    checkOutput("t5_overrun", overrun, modelOverrun);

    // Reset during ACCUM abandons the sum
    for (int c = 0; c < NUM_CH; c++) s[c*SAMPLE_W +: SAMPLE_W] = SAMPLE_W'($urandom);
    audioIn = s;
    mute    = 4'b0000;
    ready = 1'b1; tick();
    ready = 1'b0; tick(); tick();
    reset = 1'b1;
    #1;
    checkOutput("t6_valid", outValid, 0);
    checkOutput("t6_audio", $signed(audioOut), 0);
    checkOutput("t6_clip", clip, 0);
    checkOutput("t6_overrun", overrun, 0);
    tick();
    reset = 1'b0;
    for (int c = 0; c < NUM_CH; c++) modelW[c] = W_INIT;
    modelClip = 1'b0;
    modelOverrun = 1'b0;
    checkOutput("t6_weights", weights, modelPacked());
    pulses = 0;
    for (int k = 0; k < 10; k++) begin
      tick();
      if (outValid) pulses++;
    end
    checkOutput("t6_no_valid", pulses, 0);
    for (int c = 0; c < NUM_CH; c++) s[c*SAMPLE_W +: SAMPLE_W] = SAMPLE_W'($urandom);
    applyStimulus("t6_after", s, 4'b0000, 1'b0);

    // Randomized transactions with weight changes before and during accumulation
    for (int i = 0; i < 25; i++) begin
      pulses = $urandom_range(0, 3);
      for (int k = 0; k < pulses; k++) begin
        pulseWeight($urandom_range(0, NUM_CH - 1), 1'($urandom), 1'($urandom));
      end
      for (int c = 0; c < NUM_CH; c++) s[c*SAMPLE_W +: SAMPLE_W] = SAMPLE_W'($urandom);
      applyStimulus($sformatf("rnd%0d", i), s, NUM_CH'($urandom), 1'($urandom));
      checkOutput($sformatf("rnd%0d_weights", i), weights, modelPacked());
      checkOutput($sformatf("rnd%0d_overrun", i), overrun, modelOverrun);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
    $finish;
  end

endmodule
